// File: rtl/axis_packet_mux.sv
// rtl/axis_packet_mux.sv - N:1 AXI4-Stream mux with packet-atomic round-robin arbitration
// Optional output skid slice: define AXIS_PACKET_MUX_OUT_REG_EN.
module axis_packet_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8,
    parameter int ID_W   = 2,
    parameter int DEST_W = 4,
    parameter int USER_W = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_CH-1:0]          s_tvalid,
    output logic [NUM_CH-1:0]          s_tready,
    input  logic [NUM_CH*DATA_W-1:0]   s_tdata,
    input  logic [NUM_CH*STRB_W-1:0]   s_tstrb,
    input  logic [NUM_CH*STRB_W-1:0]   s_tkeep,
    input  logic [NUM_CH-1:0]          s_tlast,
    input  logic [NUM_CH*ID_W-1:0]     s_tid,
    input  logic [NUM_CH*DEST_W-1:0]   s_tdest,
    input  logic [NUM_CH*USER_W-1:0]   s_tuser,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic [STRB_W-1:0]          m_tstrb,
    output logic [STRB_W-1:0]          m_tkeep,
    output logic                       m_tlast,
    output logic [ID_W-1:0]            m_tid,
    output logic [DEST_W-1:0]          m_tdest,
    output logic [USER_W-1:0]          m_tuser,
    output logic [CH_W-1:0]            grant,
    output logic                       busy
);

    localparam int PW = DATA_W + 2 * STRB_W + 1 + ID_W + DEST_W + USER_W;
    localparam int LAST_BIT = ID_W + DEST_W + USER_W;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t            state_q;
    logic [CH_W-1:0]   grant_q;
    logic [CH_W-1:0]   last_grant_q;
    logic              busy_q;

    logic              locked;
    logic              sel_valid;
    logic [PW-1:0]     sel_pld;
    logic [PW-1:0]     out_pld;
    logic              src_rdy;
    logic              in_hs;
    logic              arb_found;
    logic [CH_W-1:0]   arb_idx;

    assign locked = (state_q == ST_LOCKED);

    // AND-OR style select: unselected channels never reach the output.
    always_comb begin
        sel_valid = 1'b0;
        sel_pld   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q == CH_W'(c)) begin
                sel_valid = s_tvalid[c];
                sel_pld   = {s_tdata[c*DATA_W +: DATA_W], s_tstrb[c*STRB_W +: STRB_W],
                             s_tkeep[c*STRB_W +: STRB_W], s_tlast[c],
                             s_tid[c*ID_W +: ID_W], s_tdest[c*DEST_W +: DEST_W],
                             s_tuser[c*USER_W +: USER_W]};
            end
        end
    end

    // Two-pass scan: channels above last_grant first, then wrap to the rest.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!arb_found && s_tvalid[c] && (CH_W'(c) > last_grant_q)) begin
                arb_found = 1'b1;
                arb_idx   = CH_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!arb_found && s_tvalid[c] && (CH_W'(c) <= last_grant_q)) begin
                arb_found = 1'b1;
                arb_idx   = CH_W'(c);
            end
        end
    end

    always_comb begin
        s_tready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s_tready[c] = locked && (grant_q == CH_W'(c)) && src_rdy;
        end
    end

    assign in_hs = locked && sel_valid && src_rdy;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant_q <= arb_idx;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (in_hs && sel_pld[LAST_BIT]) begin
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef AXIS_PACKET_MUX_OUT_REG_EN
    logic [1:0]    cnt_q, cnt_d;
    logic [PW-1:0] ent0_q, ent1_q;
    logic          push, pop;

    assign src_rdy = (cnt_q != 2'd2);
    assign push    = in_hs;
    assign pop     = (cnt_q != 2'd0) && m_tready;
    assign cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};

    // ent0 is always the head; ent1 only fills when the head is stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (pop) begin
                if (cnt_q == 2'd2) begin
                    ent0_q <= ent1_q;
                end else if (push) begin
                    ent0_q <= sel_pld;
                end
            end else if (push) begin
                if (cnt_q == 2'd0) begin
                    ent0_q <= sel_pld;
                end else begin
                    ent1_q <= sel_pld;
                end
            end
        end
    end

    assign m_tvalid = (cnt_q != 2'd0);
    assign out_pld  = ent0_q;
`else
    assign src_rdy  = m_tready;
    assign m_tvalid = locked && sel_valid;
    assign out_pld  = locked ? sel_pld : '0;
`endif

    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = out_pld;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_axis_packet_mux.sv
// tb/tb_axis_packet_mux.sv - directed + randomized bench for axis_packet_mux against a packet-level model
module tb_axis_packet_mux;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int IW  = 2;
    localparam int DSW = 4;
    localparam int UW  = 8;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    s_tvalid, s_tready, s_tlast;
    logic [N*DW-1:0] s_tdata;
    logic [N*SW-1:0] s_tstrb, s_tkeep;
    logic [N*IW-1:0] s_tid;
    logic [N*DSW-1:0] s_tdest;
    logic [N*UW-1:0] s_tuser;
    logic            m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]   m_tdata;
    logic [SW-1:0]   m_tstrb, m_tkeep;
    logic [IW-1:0]   m_tid;
    logic [DSW-1:0]  m_tdest;
    logic [UW-1:0]   m_tuser;
    logic [1:0]      grant;
    logic            busy;

    always #5 aclk = ~aclk;

    axis_packet_mux dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .grant(grant), .busy(busy)
    );

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [SW-1:0]  strb;
        logic [SW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    beat_t        q [N][$];
    logic [N-1:0] en;
    int           vectors = 0;
    int           miscompares = 0;
    int           owner = -1;
    int           mlast = N - 1;
    int           mgrant = 0;
    int           glog[$];
    int           eo[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            beat_t b;
            b = '0;
            s_tvalid[c] = 1'b0;
            if (en[c] && q[c].size() > 0) begin
                b = q[c][0];
                s_tvalid[c] = 1'b1;
            end
            s_tdata[c*DW +: DW]   = b.data;
            s_tstrb[c*SW +: SW]   = b.strb;
            s_tkeep[c*SW +: SW]   = b.keep;
            s_tlast[c]            = b.last;
            s_tid[c*IW +: IW]     = b.id;
            s_tdest[c*DSW +: DSW] = b.dest;
            s_tuser[c*UW +: UW]   = b.user;
        end
    endtask

    task automatic add_pkt(input int c, input int len, input logic [DW-1:0] base);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data = base + DW'(i);
            b.strb = SW'($urandom);
            b.keep = SW'($urandom);
            b.last = (i == len - 1);
            b.id   = IW'($urandom);
            b.dest = DSW'($urandom);
            b.user = UW'($urandom);
            q[c].push_back(b);
        end
    endtask

    function automatic bit all_empty();
        for (int c = 0; c < N; c++) if (q[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: check outputs at negedge, then advance the packet-level model.
    task automatic tick();
        logic         ev, hs;
        logic [N-1:0] erdy;
        int           pick;
        beat_t        b;
        drive();
        @(negedge aclk);
        ev   = (owner >= 0) ? s_tvalid[owner] : 1'b0;
        erdy = (owner >= 0 && m_tready) ? (N'(1) << owner) : '0;
        chk("m_tvalid", 64'(m_tvalid), 64'(ev));
        chk("s_tready", 64'(s_tready), 64'(erdy));
        chk("busy", 64'(busy), 64'(owner >= 0));
        chk("grant", 64'(grant), 64'(mgrant));
        if (ev) chk("payload", 64'({m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser}),
                    64'(q[owner][0]));
        hs = ev && m_tready;
        @(posedge aclk);
        #1;
        if (owner < 0) begin
            pick = -1;
            for (int i = 1; i <= N; i++)
                if (pick < 0 && s_tvalid[(mlast + i) % N]) pick = (mlast + i) % N;
            if (pick >= 0) begin
                owner  = pick;
                mgrant = pick;
                glog.push_back(pick);
            end
        end else if (hs) begin
            b = q[owner].pop_front();
            if (b.last) begin
                mlast = owner;
                owner = -1;
            end
        end
    endtask

    task automatic drain(input int max);
        int i = 0;
        while (!(owner < 0 && all_empty()) && i < max) begin
            tick();
            i++;
        end
        chk("drain_timeout", 64'(owner < 0 && all_empty()), 64'd1);
    endtask

    task automatic chk_order();
        chk("order_len", 64'(glog.size()), 64'(eo.size()));
        for (int i = 0; i < eo.size() && i < glog.size(); i++)
            chk("order", 64'(glog[i]), 64'(eo[i]));
        glog.delete();
    endtask

    // Asynchronous reset applied away from the edge, outputs checked before any clock.
    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        for (int c = 0; c < N; c++) q[c].delete();
        owner  = -1;
        mlast  = N - 1;
        mgrant = 0;
        drive();
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        en       = '1;
        m_tready = 1'b1;
        drive();
        do_reset();

        add_pkt(2, 3, 32'hA0);
        drain(20);
        eo = '{2};
        chk_order();

        do_reset();
        add_pkt(0, 2, 32'hB0);
        add_pkt(3, 2, 32'hC0);
        drain(30);
        eo = '{0, 3};
        chk_order();
        chk("last_grant3", 64'(grant), 64'd3);

        for (int k = 0; k < 3; k++)
            for (int c = 0; c < N; c++) add_pkt(c, 1, 32'h100 + DW'(16 * c + k));
        drain(60);
        eo = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        chk_order();

        add_pkt(1, 4, 32'hD0);
        tick();
        tick();
        m_tready = 1'b0;
        repeat (5) tick();
        m_tready = 1'b1;
        drain(20);
        eo = '{1};
        chk_order();

        add_pkt(1, 4, 32'hE0);
        tick();
        add_pkt(0, 2, 32'hF0);
        tick();
        en[1] = 1'b0;
        repeat (3) begin
            tick();
            chk("hold_grant1", 64'(grant), 64'd1);
        end
        en[1] = 1'b1;
        drain(30);
        eo = '{1, 0};
        chk_order();

        add_pkt(2, 4, 32'h50);
        tick();
        tick();
        do_reset();
        glog.delete();
        add_pkt(3, 1, 32'h63);
        add_pkt(1, 1, 32'h61);
        add_pkt(0, 1, 32'h60);
        drain(30);
        eo = '{0, 1, 3};
        chk_order();

        repeat (400) begin
            for (int c = 0; c < N; c++)
                if (q[c].size() < 2 && $urandom_range(0, 3) == 0)
                    add_pkt(c, $urandom_range(1, 4), DW'($urandom));
            en       = N'($urandom);
            m_tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        en       = '1;
        m_tready = 1'b1;
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
